host_byte_port: RTL and testbench
=================================

Name: host_byte_port

Overview:
- Pin-side responder for the external host (cocotb bench or board MCU) that drives the chip's byte pins.
- Decodes a byte-serial command stream from `host_data_in` under a 4-phase strobe/ack handshake.
- Issues 32-bit word reads and writes to the core's memory bus, and returns read data bytes on `host_data_out`.
- Holds the CPU halt line, so the host can load a program, then release the core.

Parameters:
- ADDR_W, 14, word-address width on the memory bus; taken from the low ADDR_W bits of the received 16-bit address.
- HALT_RESET, 1, value of `cpu_halt` after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- host_data_in  in  8  command/address/data byte from host (asynchronous pins)
- host_strobe  in  1  host request level (asynchronous pin)
- host_data_out  out  8  read data byte to host
- host_ack  out  1  responder acknowledge level
- host_err  out  1  sticky flag: unknown command received
- cpu_halt  out  1  1 = core held
- mem_req  out  1  memory request; held high until mem_ready
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory completion, one-cycle pulse; rdata valid with it
- mem_rdata  in  32  read data

Behaviour:
- Clock and reset:
  - One clock domain: `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - `host_ack`, `host_err`, `mem_req` and `mem_we` are 0.
  - `host_data_out`, `mem_addr` and `mem_wdata` are 0.
  - `cpu_halt` = HALT_RESET.
  - FSM enters IDLE.
- Reset mid-transaction: drops `mem_req` immediately and discards all partial state.
- Strobe synchronisation:
  - `host_strobe` passes through a 2-flop synchroniser plus a history flop.
  - A rising edge is detected when synced = 1 and history = 0.
  - `host_data_in` is sampled at the detection cycle; the host holds it stable while strobe is high.
- Handshake (4-phase):
  - On an accepted rising edge, `host_ack` rises on the next clk edge unless the byte is memory-gated (see below).
  - `host_ack` falls 1 cycle after the synced strobe is seen low.
  - A strobe edge arriving while `host_ack` = 1 is impossible by protocol and is ignored.
- Min latency: strobe pin edge to `host_ack` = 3 clk.
- FSM states: IDLE, ADDR_HI, ADDR_LO, WDATA (byte count 3..0), MEMWAIT, RDATA (byte count 3..0).
- Commands, decoded in IDLE:
  - 0x01 WRITE: ADDR_HI -> ADDR_LO -> WDATA.
    - Four data bytes, MSB first.
    - After the 4th byte: `mem_req` = 1, `mem_we` = 1 (MEMWAIT). The ack for that byte is withheld until the cycle after `mem_ready`; then go to IDLE.
  - 0x02 READ: ADDR_HI -> ADDR_LO.
    - After the low address byte: `mem_req` = 1, `mem_we` = 0. The ack is withheld until after `mem_ready`.
    - `mem_rdata` is latched into a 32-bit shift register; go to RDATA.
    - Each subsequent strobe presents the next byte, MSB first, on `host_data_out`. The byte is stable before `host_ack` rises. `host_data_in` is ignored.
    - After the 4th byte, go to IDLE.
  - 0x03 HALT: `cpu_halt` = 1, ack, stay IDLE.
  - 0x04 RUN: `cpu_halt` = 0, ack, stay IDLE.
  - Any other byte: `host_err` = 1 (sticky until reset), ack, stay IDLE.
- Address bytes are MSB first; `mem_addr` = addr16[ADDR_W-1:0].
- `mem_req` rises 1 cycle after the gating byte is captured. It stays high with `mem_addr`/`mem_wdata`/`mem_we` stable until `mem_ready`, and falls on the next edge.
- `mem_ready` while `mem_req` = 0 is ignored.
- `cpu_halt` is not altered by memory accesses; the host is responsible for halting before loading.

Optional Feature:
- Macro HOST_PORT_AUTOINC_EN.
- Defined:
  - A 16-bit last-address register is updated by every WRITE/READ and post-incremented (wraps 0xFFFF -> 0x0000) after each completed access.
  - 0x11 WRITE_NEXT goes directly to WDATA; 0x12 READ_NEXT goes directly to the memory read. Both use the stored address.
  - Reset value of the last-address register is 0.
- Not defined: 0x11 and 0x12 are unknown commands (`host_err` = 1); no last-address register exists.

Test Plan:
- Reset with `rst` high mid-WDATA -> `mem_req` = 0 and `host_ack` = 0 immediately; `cpu_halt` = 1; next byte 0x02 is decoded as READ.
- Host sends 01,00,10,DE,AD,BE,EF; memory returns `mem_ready` 5 cycles after `mem_req` -> `mem_addr` = 0x0010, `mem_wdata` = 0xDEADBEEF, `mem_we` = 1. The 7th ack rises only after `mem_ready`.
- Host sends 02,00,10; memory returns 0x12345678 -> four further strobes yield `host_data_out` 0x12, 0x34, 0x56, 0x78; FSM ends in IDLE.
- Host sends 04 then 03 -> `cpu_halt` reads 0 after the first ack, 1 after the second; no `mem_req` pulses.
- Host sends 0x7F -> `host_err` = 1 and is acked; a following valid READ still works and `host_err` stays 1.
- With HOST_PORT_AUTOINC_EN defined: WRITE at 0xFFFF, then 11 + 4 bytes -> second access at `mem_addr` = 0x0000 (wrap). Without the macro: 11 -> `host_err` = 1.

Source files
------------

// File: rtl/host_byte_port.sv
// -----------------------------------------------------------------------------
// host_byte_port
//
// Pin-side responder for an external host driving the chip's byte pins.
// The host pushes a byte-serial command stream under a 4-phase strobe/ack
// handshake; this block decodes it into 32-bit word reads/writes on the core
// memory bus, returns read data a byte at a time, and owns the CPU halt line
// so the host can load a program before releasing the core.
//
// Command bytes (decoded in IDLE):
//   0x01 WRITE  addr_hi addr_lo d3 d2 d1 d0   (ack of d0 waits for memory)
//   0x02 READ   addr_hi addr_lo               (ack of addr_lo waits for memory)
//               then four strobes return d3..d0 on host_data_out
//   0x03 HALT   0x04 RUN   anything else sets the sticky host_err flag
//
// Optional build macro HOST_PORT_AUTOINC_EN:
//   keeps the 16-bit address of the last access, post-incremented after each
//   completed access, and adds 0x11 WRITE_NEXT / 0x12 READ_NEXT which reuse
//   it. Without the macro those two bytes are unknown commands.
// -----------------------------------------------------------------------------
module host_byte_port #(
  parameter int ADDR_W     = 14,
  parameter bit HALT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_data_in,
  input  logic              host_strobe,
  output logic [7:0]        host_data_out,
  output logic              host_ack,
  output logic              host_err,
  output logic              cpu_halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] CMD_WRITE      = 8'h01;
  localparam logic [7:0] CMD_READ       = 8'h02;
  localparam logic [7:0] CMD_HALT       = 8'h03;
  localparam logic [7:0] CMD_RUN        = 8'h04;
`ifdef HOST_PORT_AUTOINC_EN
  localparam logic [7:0] CMD_WRITE_NEXT = 8'h11;
  localparam logic [7:0] CMD_READ_NEXT  = 8'h12;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    WDATA,
    MEMWAIT,
    RDATA
  } state_t;

  state_t      state;
  state_t      state_next;

  // Strobe synchroniser: meta -> sync, plus history for edge detection.
  logic        strobe_meta;
  logic        strobe_sync;
  logic        strobe_hist;
  logic        accept;

  // Datapath registers.
  logic [15:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_sr;
  logic [1:0]  byte_cnt;
  logic        op_we;

  // Control decodes produced by the output logic.
  logic        ack_set;
  logic        addr_hi_load;
  logic        addr_lo_load;
  logic        wdata_shift;
  logic        rdata_load;
  logic        rdata_shift;
  logic        cnt_load;
  logic        we_load;
  logic        we_val;
  logic        halt_set;
  logic        halt_clr;
  logic        err_set;

  // Bring the asynchronous strobe pin into the clk domain and keep one cycle
  // of history so a rising edge can be seen.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; with blocking assignments the
  // synchroniser would collapse into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_hist <= 1'b0;
    end else begin
      strobe_meta <= host_strobe;
      strobe_sync <= strobe_meta;
      strobe_hist <= strobe_sync;
    end
  end

  // A new byte is accepted on a synced rising edge. An edge while the ack is
  // still high, or while a memory access is outstanding, breaks the protocol
  // and is dropped.
  assign accept = strobe_sync && !strobe_hist && !host_ack && (state != MEMWAIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: walk the command framing.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (host_data_in)
            CMD_WRITE,
            CMD_READ:       state_next = ADDR_HI;
`ifdef HOST_PORT_AUTOINC_EN
            CMD_WRITE_NEXT: state_next = WDATA;
            CMD_READ_NEXT:  state_next = MEMWAIT;
`endif
            default:        state_next = IDLE;
          endcase
        end
      end
      ADDR_HI: begin
        if (accept) state_next = ADDR_LO;
      end
      ADDR_LO: begin
        if (accept) state_next = op_we ? WDATA : MEMWAIT;
      end
      WDATA: begin
        if (accept && (byte_cnt == 2'd0)) state_next = MEMWAIT;
      end
      MEMWAIT: begin
        if (mem_ready) state_next = op_we ? IDLE : RDATA;
      end
      RDATA: begin
        if (accept && (byte_cnt == 2'd0)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: per-state control strobes for the datapath plus the memory
  // request, which is simply "an access is outstanding".
  always_comb begin
    ack_set      = 1'b0;
    addr_hi_load = 1'b0;
    addr_lo_load = 1'b0;
    wdata_shift  = 1'b0;
    rdata_load   = 1'b0;
    rdata_shift  = 1'b0;
    cnt_load     = 1'b0;
    we_load      = 1'b0;
    we_val       = 1'b0;
    halt_set     = 1'b0;
    halt_clr     = 1'b0;
    err_set      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          we_load = 1'b1;
          case (host_data_in)
            CMD_WRITE: begin
              ack_set = 1'b1;
              we_val  = 1'b1;
            end
            CMD_READ: begin
              ack_set = 1'b1;
            end
            CMD_HALT: begin
              ack_set  = 1'b1;
              halt_set = 1'b1;
            end
            CMD_RUN: begin
              ack_set  = 1'b1;
              halt_clr = 1'b1;
            end
`ifdef HOST_PORT_AUTOINC_EN
            CMD_WRITE_NEXT: begin
              ack_set  = 1'b1;
              we_val   = 1'b1;
              cnt_load = 1'b1;
            end
            CMD_READ_NEXT: begin
              // Ack held back until the read data is in hand.
              we_val = 1'b0;
            end
`endif
            default: begin
              ack_set = 1'b1;
              err_set = 1'b1;
            end
          endcase
        end
      end
      ADDR_HI: begin
        if (accept) begin
          ack_set      = 1'b1;
          addr_hi_load = 1'b1;
        end
      end
      ADDR_LO: begin
        if (accept) begin
          addr_lo_load = 1'b1;
          // A read launches the access now, so its ack waits for memory.
          if (op_we) begin
            ack_set  = 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      WDATA: begin
        if (accept) begin
          wdata_shift = 1'b1;
          // The last data byte launches the write; its ack waits for memory.
          if (byte_cnt != 2'd0) ack_set = 1'b1;
        end
      end
      MEMWAIT: begin
        mem_req = 1'b1;
        mem_we  = op_we;
        if (mem_ready) begin
          ack_set = 1'b1;
          if (!op_we) begin
            rdata_load = 1'b1;
            cnt_load   = 1'b1;
          end
        end
      end
      RDATA: begin
        if (accept) begin
          ack_set     = 1'b1;
          rdata_shift = 1'b1;
        end
      end
      default: begin
        ack_set = 1'b0;
      end
    endcase
  end

  // Acknowledge level: raised for an accepted (or memory-completed) byte,
  // dropped the cycle after the synced strobe is seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_ack <= 1'b0;
    end else if (ack_set) begin
      host_ack <= 1'b1;
    end else if (host_ack && !strobe_sync) begin
      host_ack <= 1'b0;
    end
  end

  // Datapath: address/data assembly, read shift-out, byte counter, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= 16'h0000;
      wdata_reg     <= 32'h0000_0000;
      rdata_sr      <= 32'h0000_0000;
      host_data_out <= 8'h00;
      byte_cnt      <= 2'd0;
      op_we         <= 1'b0;
      cpu_halt      <= HALT_RESET;
      host_err      <= 1'b0;
    end else begin
      if (addr_hi_load) addr_reg[15:8] <= host_data_in;
      if (addr_lo_load) addr_reg[7:0]  <= host_data_in;
`ifdef HOST_PORT_AUTOINC_EN
      // Post-increment the remembered address once the access completes.
      if ((state == MEMWAIT) && mem_ready) addr_reg <= addr_reg + 16'd1;
`endif

      if (wdata_shift) wdata_reg <= {wdata_reg[23:0], host_data_in};

      if (rdata_load) begin
        rdata_sr <= mem_rdata;
      end else if (rdata_shift) begin
        rdata_sr <= {rdata_sr[23:0], 8'h00};
      end

      // The returned byte updates on the same edge as the ack, so it is
      // already settled when the host sees the ack.
      if (rdata_shift) host_data_out <= rdata_sr[31:24];

      if (cnt_load) begin
        byte_cnt <= 2'd3;
      end else if (wdata_shift || rdata_shift) begin
        byte_cnt <= byte_cnt - 2'd1;
      end

      if (we_load) op_we <= we_val;

      if (halt_set) begin
        cpu_halt <= 1'b1;
      end else if (halt_clr) begin
        cpu_halt <= 1'b0;
      end

      if (err_set) host_err <= 1'b1;
    end
  end

  assign mem_addr  = ADDR_W'(addr_reg);
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_host_byte_port.sv
// -----------------------------------------------------------------------------
// tb_host_byte_port
//
// Drives the host pins with the 4-phase handshake, plays a memory with a
// configurable response delay, and checks the DUT against a command-level
// model. Expected memory requests and expected read bytes are queued when a
// command is issued; independent monitors pop and compare whenever the DUT
// presents a memory request or a read-data ack. Honours HOST_PORT_AUTOINC_EN.
// -----------------------------------------------------------------------------
module tb_host_byte_port;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        host_data_in;
  logic              host_strobe;
  logic [7:0]        host_data_out;
  logic              host_ack;
  logic              host_err;
  logic              cpu_halt;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  host_byte_port #(.ADDR_W(ADDR_W), .HALT_RESET(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_data_in  (host_data_in),
    .host_strobe   (host_strobe),
    .host_data_out (host_data_out),
    .host_ack      (host_ack),
    .host_err      (host_err),
    .cpu_halt      (cpu_halt),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } mem_op_t;

  // Scoreboard queues.
  mem_op_t     exp_mem_q[$];
  logic [31:0] rdata_q[$];
  logic [7:0]  rbyte_q[$];

  // Host-visible model state.
  bit          exp_halt;
  bit          exp_err;
  logic [15:0] last_addr;

  int checks    = 0;
  int failures  = 0;
  int ready_cnt = 0;
  int mem_delay = 5;
  bit mem_stall = 1'b0;
  bit rd_phase  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_halt  = 1'b1;
    exp_err   = 1'b0;
    last_addr = 16'h0000;
    exp_mem_q.delete();
    rdata_q.delete();
    rbyte_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: answers each request after mem_delay cycles, and throws
  // stray mem_ready pulses while idle, which the DUT must ignore.
  // ---------------------------------------------------------------------------
  initial begin
    int wait_n;
    wait_n    = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        wait_n = 0;
        if (!rst && !mem_req && ($urandom_range(0, 7) == 0)) begin
          mem_ready = 1'b1;
          mem_rdata = $urandom;
        end
      end else if (!mem_stall) begin
        wait_n++;
        if (wait_n >= mem_delay) begin
          mem_ready = 1'b1;
          if (mem_we) mem_rdata = $urandom;
          else        mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
          ready_cnt++;
          wait_n = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory monitor: compare each new request with the queued expectation and
  // require the request fields to hold steady until it drops.
  // ---------------------------------------------------------------------------
  initial begin
    logic    prev_req;
    mem_op_t cur;
    mem_op_t e;
    prev_req = 1'b0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected: request we=%0b addr=0x%0h, none expected", mem_we, mem_addr);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
          check("mem_addr", {18'h0, mem_addr}, {18'h0, e.addr});
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
        cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
      end else if (mem_req && prev_req) begin
        check("mem_stable", {31'h0, ({mem_we, mem_addr, mem_wdata} === cur)}, 32'h1);
      end
      prev_req = mem_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data monitor: every ack during a read-data phase presents a byte.
  // ---------------------------------------------------------------------------
  initial begin
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (host_ack && !prev_ack && rd_phase) begin
        if (rbyte_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: byte 0x%0h with none expected", host_data_out);
        end else begin
          check("rd_byte", {24'h0, host_data_out}, {24'h0, rbyte_q.pop_front()});
        end
      end
      prev_ack = host_ack;
    end
  end

  // ---------------------------------------------------------------------------
  // Host-side handshake for one byte. Ungated bytes must ack exactly 3 clocks
  // after the pin edge; gated bytes must ack only after one mem_ready.
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] d, input bit gated);
    int n;
    int r0;
    @(negedge clk);
    host_data_in = d;
    host_strobe  = 1'b1;
    n  = 0;
    r0 = ready_cnt;
    while (!host_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!host_ack) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: no ack for byte 0x%0h", d);
    end else if (gated) begin
      check("ack_after_ready", ready_cnt - r0, 1);
    end else begin
      check("ack_latency", n, 3);
    end
    host_strobe = 1'b0;
    n = 0;
    while (host_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_release", {31'h0, host_ack}, 32'h0);
  endtask

  task automatic check_status();
    check("cpu_halt", {31'h0, cpu_halt}, {31'h0, exp_halt});
    check("host_err", {31'h0, host_err}, {31'h0, exp_err});
  endtask

  task automatic read_phase(input logic [31:0] rd);
    for (int i = 3; i >= 0; i--) rbyte_q.push_back(rd[i*8 +: 8]);
    rd_phase = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    rd_phase = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    exp_mem_q.push_back('{we: 1'b1, addr: a[ADDR_W-1:0], wdata: d});
    last_addr = a + 16'd1;
    send_byte(8'h01, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], i == 0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] rd);
    exp_mem_q.push_back('{we: 1'b0, addr: a[ADDR_W-1:0], wdata: 32'h0});
    rdata_q.push_back(rd);
    last_addr = a + 16'd1;
    send_byte(8'h02, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b1);
    read_phase(rd);
  endtask

`ifdef HOST_PORT_AUTOINC_EN
  task automatic do_write_next(input logic [31:0] d);
    exp_mem_q.push_back('{we: 1'b1, addr: last_addr[ADDR_W-1:0], wdata: d});
    last_addr = last_addr + 16'd1;
    send_byte(8'h11, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], i == 0);
  endtask

  task automatic do_read_next(input logic [31:0] rd);
    exp_mem_q.push_back('{we: 1'b0, addr: last_addr[ADDR_W-1:0], wdata: 32'h0});
    rdata_q.push_back(rd);
    last_addr = last_addr + 16'd1;
    send_byte(8'h12, 1'b1);
    read_phase(rd);
  endtask
`endif

  // Single-byte commands: HALT, RUN, or anything unknown.
  task automatic do_simple(input logic [7:0] c);
    if (c == 8'h03)      exp_halt = 1'b1;
    else if (c == 8'h04) exp_halt = 1'b0;
    else                 exp_err  = 1'b1;
    send_byte(c, 1'b0);
  endtask

  function automatic bit is_known(input logic [7:0] c);
    bit k;
    k = (c == 8'h01) || (c == 8'h02) || (c == 8'h03) || (c == 8'h04);
`ifdef HOST_PORT_AUTOINC_EN
    if ((c == 8'h11) || (c == 8'h12)) k = 1'b1;
`endif
    return k;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst         = 1'b1;
    host_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Watchdog: a hung run reports and stops.
  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] c;
    int         op;
    int         n;

    rst          = 1'b1;
    host_strobe  = 1'b0;
    host_data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_ack", {31'h0, host_ack}, 32'h0);
    check("rst_err", {31'h0, host_err}, 32'h0);
    check("rst_halt", {31'h0, cpu_halt}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_data_out", {24'h0, host_data_out}, 32'h0);
    check("rst_mem_addr", {18'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xDEADBEEF to 0x0010 with a 5-cycle memory.
    mem_delay = 5;
    do_write(16'h0010, 32'hDEAD_BEEF);
    check_status();

    // Read 0x0010 returning 0x12345678, then the FSM must be back in IDLE.
    do_read(16'h0010, 32'h1234_5678);
    check_status();

    // RUN then HALT.
    do_simple(8'h04);
    check_status();
    do_simple(8'h03);
    check_status();

    // Unknown command sets the sticky error; a following read still works.
    do_simple(8'h7F);
    check_status();
    do_read(16'h2345, 32'hA5C3_0F96);
    check_status();

    // Reset in the middle of the write data bytes.
    do_simple(8'h04);
    check_status();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    host_data_in = 8'hCC;
    host_strobe  = 1'b1;
    n = 0;
    while (!host_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_ack", {31'h0, host_ack}, 32'h1);
    rst = 1'b1;
    #1;
    check("midwdata_rst_ack", {31'h0, host_ack}, 32'h0);
    check("midwdata_rst_req", {31'h0, mem_req}, 32'h0);
    check("midwdata_rst_halt", {31'h0, cpu_halt}, 32'h1);
    host_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_read(16'h0120, 32'hCAFE_F00D);
    check_status();

    // Reset while a write is waiting on memory.
    mem_stall = 1'b1;
    exp_mem_q.push_back('{we: 1'b1, addr: 14'h0333, wdata: 32'h0102_0304});
    send_byte(8'h01, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    @(negedge clk);
    host_data_in = 8'h04;
    host_strobe  = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("memwait_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("memwait_rst_req", {31'h0, mem_req}, 32'h0);
    check("memwait_rst_we", {31'h0, mem_we}, 32'h0);
    check("memwait_rst_ack", {31'h0, host_ack}, 32'h0);
    host_strobe = 1'b0;
    mem_stall   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

`ifdef HOST_PORT_AUTOINC_EN
    // Address wrap: write at 0xFFFF, then WRITE_NEXT lands at 0x0000.
    do_write(16'hFFFF, 32'h1111_2222);
    do_write_next(32'h3333_4444);
    do_read_next(32'h5555_6666);
    check_status();
`else
    // Without the auto-increment option 0x11 is an unknown command.
    do_simple(8'h11);
    check_status();
`endif

    // Randomised command mix.
    for (int t = 0; t < 40; t++) begin
      mem_delay = $urandom_range(1, 6);
`ifdef HOST_PORT_AUTOINC_EN
      op = $urandom_range(0, 7);
`else
      op = $urandom_range(0, 5);
`endif
      case (op)
        0, 1: do_write(16'($urandom), $urandom);
        2, 3: do_read(16'($urandom), $urandom);
        4:    do_simple(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h04);
        5: begin
          c = 8'($urandom);
          while (is_known(c)) c = 8'($urandom);
          do_simple(c);
        end
`ifdef HOST_PORT_AUTOINC_EN
        6:    do_write_next($urandom);
        7:    do_read_next($urandom);
`endif
        default: do_simple(8'h03);
      endcase
      check_status();
    end

    repeat (10) @(negedge clk);
    check("mem_q_drained", exp_mem_q.size(), 0);
    check("rbyte_q_drained", rbyte_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
